md5_round_ctrl: RTL and testbench
=================================

// Module: md5_round_ctrl
// PURPOSE
//  Sequencer for one MD5 compression (64 steps) over a 512-bit block.
//  - Drives the step index into the sine-constant table (sint_table.index), one step per cycle.
//  - Emits per-step message-word index, rotate amount and round-function select to the datapath.
//  - Emits load/add strobes for the chaining registers; start/busy/done handshake to the block feeder.
// PARAMETERS
//  STEP_W     6  step counter width; must be 6 (64 steps)
//  MSG_IDX_W  4  message word index width; must be 4 (16 words)
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  reset, asynchronous, active-low
//  start       in   1  begin compression of the presented block; sampled in IDLE only
//  abort       in   1  synchronous cancel; return to IDLE without done
//  busy        out  1  high from the cycle after an accepted start through the FINAL cycle
//  done        out  1  one-cycle pulse in the FINAL cycle
//  step_valid  out  1  step_idx/msg_idx/shift_amt/func_sel are valid this cycle (RUN only)
//  step_idx    out  6  current step 0..63; drives sint_table index
//  msg_idx     out  4  message word g for this step
//  shift_amt   out  5  left-rotate amount s for this step
//  func_sel    out  2  0=F 1=G 2=H 3=I (equals step_idx[5:4])
//  load_state  out  1  high on step 0: datapath loads A..D from chaining value
//  add_en      out  1  high in FINAL: chaining value += A..D
//  step_ready  in   1  [MD5_STEP_STALL_EN only] datapath accepts current step
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 (busy, done, step_valid, step_idx, msg_idx,
//    shift_amt, func_sel, load_state, add_en).
//  FSM IDLE -> RUN -> FINAL -> IDLE.
//  - IDLE:  start=1 & abort=0 -> RUN, step=0.
//  - RUN:   step advances +1 per cycle; at step 63 advance -> FINAL.
//  - FINAL: one cycle, add_en=1, done=1 -> IDLE.
//  Timing: start sampled at cycle 0.
//  - Step 0 at cycle 1, with load_state=1.
//  - Step 63 at cycle 64.
//  - FINAL (done/add_en) at cycle 65; IDLE at cycle 66.
//  - Total 65 cycles of busy.
//  Decode, with i=step_idx and r=i[5:4]:
//  - msg_idx: r0: i[3:0]; r1: (5i+1) mod 16; r2: (3i+5) mod 16; r3: (7i) mod 16.
//    Arithmetic is done in 4 bits; the carry out is discarded.
//  - shift_amt = S[r][i[1:0]] with S0={7,12,17,22}, S1={5,9,14,20}, S2={4,11,16,23},
//    S3={6,10,15,21}.
//  - Decode outputs read 0 when step_valid=0.
//  Boundary conditions:
//  - start while busy: ignored, no queuing. start and done in the same cycle: start is
//    ignored (FSM is in FINAL); the feeder reissues start in IDLE.
//  - abort: honoured in any state, and wins over start and over the step advance.
//    The next cycle is IDLE with outputs at their reset values. No done or add_en is
//    produced. Abort in FINAL suppresses nothing already driven that cycle.
//  - Step counter never wraps inside RUN; 63 exits to FINAL.
//  - rst_n low mid-compression: immediate return to IDLE, outputs at reset values;
//    no partial done.
// CONFIGURATION
//  MD5_STEP_STALL_EN defined:
//  - Adds the step_ready input.
//  - In RUN the step holds while step_valid=1 & step_ready=0. All step outputs stay
//    stable and load_state stays high while step 0 is held.
//  - Advance/exit to FINAL only on step_ready=1.
//  - Latency becomes 65 + stall cycles.
//  MD5_STEP_STALL_EN undefined:
//  - No step_ready port; the datapath must accept one step per cycle.
// STRUCTURE
//  Package md5_pkg:
//  - FSM state encoding (IDLE, RUN, FINAL).
//  - func_sel encodings F_SEL/G_SEL/H_SEL/I_SEL.
//  - Shift table constant S[4][4].
//  - MD5_STEPS=64 and MD5_WORDS=16.
//  Sub-module md5_step_decode: purely combinational step_idx -> {msg_idx, shift_amt, func_sel}.
//  sint_table is instantiated by the parent alongside this block; it is not instantiated here.
// TESTING
//  1. Reset then idle: rst_n low at random point -> all outputs 0, busy=0.
//     100 idle cycles without start -> no activity.
//  2. Single start -> step_idx 0..63 on cycles 1..64, load_state only at cycle 1,
//     done & add_en at cycle 65, busy high for exactly 65 cycles.
//  3. Decode check at steps 0,1,16,17,32,33,48,49,63:
//     msg_idx = 0,1,1,6,5,8,0,7,9; shift_amt = 7,12,5,9,4,11,6,10,21;
//     func_sel per round.
//  4. start held high continuously -> back-to-back compressions 66 cycles apart;
//     start during busy or during FINAL never restarts the step count.
//  5. abort at step 30 -> IDLE next cycle, no done/add_en; new start gives a clean
//     step 0. rst_n pulse at step 40 -> same result.
//  6. (MD5_STEP_STALL_EN) step_ready low 3 cycles at step 0 and 5 cycles at step 63
//     -> outputs frozen, load_state held, done at cycle 65+8.

Source files
------------

// File: rtl/md5_pkg.sv
// MD5 round controller shared types and constants.
// State encoding, round selects, per-round rotate table.
package md5_pkg;

   localparam int MD5_STEPS = 64;
   localparam int MD5_WORDS = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FINAL = 2'd2
   } state_t;

   localparam logic [1:0] F_SEL = 2'd0;
   localparam logic [1:0] G_SEL = 2'd1;
   localparam logic [1:0] H_SEL = 2'd2;
   localparam logic [1:0] I_SEL = 2'd3;

   localparam logic [4:0] S [4][4] = '{
      '{5'd7, 5'd12, 5'd17, 5'd22},
      '{5'd5, 5'd9,  5'd14, 5'd20},
      '{5'd4, 5'd11, 5'd16, 5'd23},
      '{5'd6, 5'd10, 5'd15, 5'd21}
   };

endpackage

// File: rtl/md5_round_ctrl_if.sv
// Feeder/datapath bundle for the MD5 round controller.
// MD5_STEP_STALL_EN adds step_ready for datapath back-pressure.
interface md5_round_ctrl_if;
   import md5_pkg::*;

   logic                           start;
   logic                           abort;
   logic                           busy;
   logic                           done;
   logic                           step_valid;
   logic [$clog2(MD5_STEPS)-1:0]   step_idx;
   logic [$clog2(MD5_WORDS)-1:0]   msg_idx;
   logic [4:0]                     shift_amt;
   logic [1:0]                     func_sel;
   logic                           load_state;
   logic                           add_en;

`ifdef MD5_STEP_STALL_EN
   logic                           step_ready;

   modport master (
      output start, abort, step_ready,
      input  busy, done, step_valid, step_idx, msg_idx,
      input  shift_amt, func_sel, load_state, add_en
   );

   modport slave (
      input  start, abort, step_ready,
      output busy, done, step_valid, step_idx, msg_idx,
      output shift_amt, func_sel, load_state, add_en
   );
`else
   modport master (
      output start, abort,
      input  busy, done, step_valid, step_idx, msg_idx,
      input  shift_amt, func_sel, load_state, add_en
   );

   modport slave (
      input  start, abort,
      output busy, done, step_valid, step_idx, msg_idx,
      output shift_amt, func_sel, load_state, add_en
   );
`endif

endinterface

// File: rtl/md5_step_decode.sv
// Combinational step index -> message word, rotate, round select.
// Message schedule arithmetic is modulo 16 (carry dropped).
module md5_step_decode
   import md5_pkg::*;
(
   input  logic [5:0] step_idx,
   output logic [3:0] msg_idx,
   output logic [4:0] shift_amt,
   output logic [1:0] func_sel
);

   logic [1:0] r;
   logic [3:0] lo;

   assign r         = step_idx[5:4];
   assign lo        = step_idx[3:0];
   assign func_sel  = r;
   assign shift_amt = S[r][step_idx[1:0]];

   // per-round message word permutation
   always_comb begin
      msg_idx = lo;
      unique case (1'b1)
         (r == F_SEL): msg_idx = lo;
         (r == G_SEL): msg_idx = lo * 4'd5 + 4'd1;
         (r == H_SEL): msg_idx = lo * 4'd3 + 4'd5;
         (r == I_SEL): msg_idx = lo * 4'd7;
         default:      msg_idx = lo;
      endcase
   end

endmodule

// File: rtl/md5_round_ctrl.sv
// MD5 64-step sequencer: IDLE -> RUN (64 steps) -> FINAL -> IDLE.
// MD5_STEP_STALL_EN: hold the current step until step_ready.
module md5_round_ctrl
   import md5_pkg::*;
#(
   parameter int STEP_W    = 6,
   parameter int MSG_IDX_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   md5_round_ctrl_if.slave   bus
);

   state_t                state_q, state_d;
   logic [STEP_W-1:0]     step_q, step_d;
   logic                  adv;
   logic                  run;
   logic                  fin;
   logic [MSG_IDX_W-1:0]  dec_msg;
   logic [4:0]            dec_shift;
   logic [1:0]            dec_func;

`ifdef MD5_STEP_STALL_EN
   assign adv = bus.step_ready;
`else
   assign adv = 1'b1;
`endif

   // state and step counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
      end
   end

   // next state; abort overrides start and step advance
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      if (bus.abort) begin
         state_d = IDLE;
         step_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_d = RUN;
                  step_d  = '0;
               end
            end
            RUN: begin
               if (adv) begin
                  if (step_q == STEP_W'(MD5_STEPS - 1)) begin
                     state_d = FINAL;
                     step_d  = '0;
                  end else begin
                     step_d = step_q + STEP_W'(1);
                  end
               end
            end
            FINAL: begin
               state_d = IDLE;
               step_d  = '0;
            end
            default: begin
               state_d = IDLE;
               step_d  = '0;
            end
         endcase
      end
   end

   md5_step_decode u_dec (
      .step_idx  (step_q),
      .msg_idx   (dec_msg),
      .shift_amt (dec_shift),
      .func_sel  (dec_func)
   );

   assign run = (state_q == RUN);
   assign fin = (state_q == FINAL);

   assign bus.busy       = run | fin;
   assign bus.done       = fin;
   assign bus.add_en     = fin;
   assign bus.step_valid = run;
   assign bus.step_idx   = run ? step_q : '0;
   assign bus.msg_idx    = run ? dec_msg : '0;
   assign bus.shift_amt  = run ? dec_shift : '0;
   assign bus.func_sel   = run ? dec_func : '0;
   assign bus.load_state = run & (step_q == '0);

endmodule

// File: tb/tb_md5_round_ctrl.sv
// Self-checking bench for md5_round_ctrl.
// Scoreboard of expected step records, one task per scenario.
module tb_md5_round_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   typedef struct {
      int step;
      int msg;
      int shift;
      int func;
      int load;
   } exp_t;

   exp_t sb[$];

   int stab [16] = '{7, 12, 17, 22, 5, 9, 14, 20,
                     4, 11, 16, 23, 6, 10, 15, 21};

   md5_round_ctrl_if bus();

   md5_round_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic int m_msg(int i);
      case (i / 16)
         0:       return i % 16;
         1:       return (5 * i + 1) % 16;
         2:       return (3 * i + 5) % 16;
         default: return (7 * i) % 16;
      endcase
   endfunction

   function automatic logic [21:0] outs();
      return {bus.busy, bus.done, bus.step_valid, bus.step_idx,
              bus.msg_idx, bus.shift_amt, bus.func_sel,
              bus.load_state, bus.add_en};
   endfunction

   task automatic push_run();
      exp_t e;
      for (int i = 0; i < 64; i++) begin
         e.step  = i;
         e.msg   = m_msg(i);
         e.shift = stab[(i / 16) * 4 + (i % 4)];
         e.func  = i / 16;
         e.load  = (i == 0) ? 1 : 0;
         sb.push_back(e);
      end
   endtask

   task automatic test_reset();
      int act = 0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      #($urandom_range(1, 4));
      rst_n = 1'b0;
      #1;
      checks++;
      if (outs() !== '0) begin
         failures++;
         $display("FAIL reset_outs got=%h exp=0", outs());
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (outs() !== '0) act++;
      end
      checks++;
      if (act !== 0) begin
         failures++;
         $display("FAIL idle_activity got=%0d exp=0", act);
      end
   endtask

   task automatic test_single();
      int busy_n = 0;
      int done_at = -1;
      int add_at = -1;
      int load_n = 0;
      int load_at = -1;
      int idle_at = -1;
      exp_t e;
      push_run();
      @(negedge clk);
      bus.start = 1'b1;
      for (int k = 1; k <= 70; k++) begin
         @(negedge clk);
         if (k == 1) bus.start = 1'b0;
         if (bus.busy) busy_n++;
         if (bus.done && done_at < 0) done_at = k;
         if (bus.add_en && add_at < 0) add_at = k;
         if (bus.load_state) begin
            load_n++;
            load_at = k;
         end
         if (!bus.busy && idle_at < 0) idle_at = k;
         if (k == 66) begin
            checks++;
            if (outs() !== '0) begin
               failures++;
               $display("FAIL idle_after_final got=%h exp=0", outs());
            end
         end
         if (bus.step_valid) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL sb_underflow cycle=%0d", k);
            end else begin
               e = sb.pop_front();
               if (bus.step_idx !== 6'(e.step) ||
                   bus.msg_idx !== 4'(e.msg) ||
                   bus.shift_amt !== 5'(e.shift) ||
                   bus.func_sel !== 2'(e.func) ||
                   bus.load_state !== 1'(e.load)) begin
                  failures++;
                  $display("FAIL step_%0d got=%0d/%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d/%0d",
                           e.step, bus.step_idx, bus.msg_idx, bus.shift_amt,
                           bus.func_sel, bus.load_state, e.step, e.msg,
                           e.shift, e.func, e.load);
               end
            end
         end
      end
      checks++;
      if (done_at !== 65 || add_at !== 65) begin
         failures++;
         $display("FAIL done_cycle got=%0d/%0d exp=65/65", done_at, add_at);
      end
      checks++;
      if (busy_n !== 65) begin
         failures++;
         $display("FAIL busy_len got=%0d exp=65", busy_n);
      end
      checks++;
      if (load_n !== 1 || load_at !== 1) begin
         failures++;
         $display("FAIL load_state got=%0d@%0d exp=1@1", load_n, load_at);
      end
      checks++;
      if (idle_at !== 66) begin
         failures++;
         $display("FAIL idle_cycle got=%0d exp=66", idle_at);
      end
      checks++;
      if (sb.size() !== 0) begin
         failures++;
         $display("FAIL sb_leftover got=%0d exp=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_decode();
      int steps [9] = '{0, 1, 16, 17, 32, 33, 48, 49, 63};
      int emsg  [9] = '{0, 1, 1, 6, 5, 8, 0, 7, 9};
      int esh   [9] = '{7, 12, 5, 9, 4, 11, 6, 10, 21};
      int cmsg  [64];
      int csh   [64];
      int cfs   [64];
      for (int i = 0; i < 64; i++) begin
         cmsg[i] = -1;
         csh[i]  = -1;
         cfs[i]  = -1;
      end
      @(negedge clk);
      bus.start = 1'b1;
      for (int k = 1; k <= 66; k++) begin
         @(negedge clk);
         if (k == 1) bus.start = 1'b0;
         if (bus.step_valid) begin
            cmsg[bus.step_idx] = int'(bus.msg_idx);
            csh[bus.step_idx]  = int'(bus.shift_amt);
            cfs[bus.step_idx]  = int'(bus.func_sel);
         end
      end
      for (int j = 0; j < 9; j++) begin
         checks++;
         if (cmsg[steps[j]] !== emsg[j] || csh[steps[j]] !== esh[j] ||
             cfs[steps[j]] !== steps[j] / 16) begin
            failures++;
            $display("FAIL decode_step%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     steps[j], cmsg[steps[j]], csh[steps[j]], cfs[steps[j]],
                     emsg[j], esh[j], steps[j] / 16);
         end
      end
   endtask

   task automatic test_back_to_back();
      int loads[$];
      int viol = 0;
      int prev_v = 0;
      int prev_s = 0;
      int drained = 0;
      @(negedge clk);
      bus.start = 1'b1;
      for (int k = 1; k <= 135; k++) begin
         @(negedge clk);
         if (bus.load_state) loads.push_back(k);
         if (bus.step_valid) begin
            if (prev_v != 0 && int'(bus.step_idx) != prev_s + 1) viol++;
            if (prev_v == 0 && bus.step_idx !== 6'd0) viol++;
            prev_s = int'(bus.step_idx);
         end
         prev_v = bus.step_valid ? 1 : 0;
      end
      bus.start = 1'b0;
      checks++;
      if (loads.size() !== 3) begin
         failures++;
         $display("FAIL b2b_starts got=%0d exp=3", loads.size());
      end else begin
         checks++;
         if (loads[0] !== 1 || loads[1] !== 67 || loads[2] !== 133) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d,%0d,%0d exp=1,67,133",
                     loads[0], loads[1], loads[2]);
         end
      end
      checks++;
      if (viol !== 0) begin
         failures++;
         $display("FAIL b2b_continuity got=%0d exp=0", viol);
      end
      for (int k = 0; k < 80 && drained == 0; k++) begin
         @(negedge clk);
         if (!bus.busy) drained = 1;
      end
      checks++;
      if (drained !== 1) begin
         failures++;
         $display("FAIL b2b_drain got=busy exp=idle");
      end
   endtask

   task automatic test_abort();
      int found = 0;
      int dn = 0;
      int ok = 0;
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      checks++;
      if (outs() !== '0) begin
         failures++;
         $display("FAIL abort_beats_start got=%h exp=0", outs());
      end
      bus.start = 1'b1;
      for (int k = 1; k <= 40 && found == 0; k++) begin
         @(negedge clk);
         if (k == 1) bus.start = 1'b0;
         if (bus.step_valid && bus.step_idx == 6'd30) found = 1;
      end
      checks++;
      if (found !== 1) begin
         failures++;
         $display("FAIL abort_reach30 got=missing exp=step30");
      end
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      checks++;
      if (outs() !== '0) begin
         failures++;
         $display("FAIL abort_outs got=%h exp=0", outs());
      end
      repeat (70) begin
         @(negedge clk);
         if (bus.done || bus.add_en || bus.busy) dn++;
      end
      checks++;
      if (dn !== 0) begin
         failures++;
         $display("FAIL abort_nodone got=%0d exp=0", dn);
      end
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (!(bus.step_valid && bus.step_idx == 6'd0 && bus.load_state)) begin
         failures++;
         $display("FAIL abort_restart got=%b/%0d/%b exp=1/0/1",
                  bus.step_valid, bus.step_idx, bus.load_state);
      end
      found = 0;
      for (int k = 2; k <= 45 && found == 0; k++) begin
         @(negedge clk);
         if (bus.step_valid && bus.step_idx == 6'd40) found = 1;
      end
      checks++;
      if (found !== 1) begin
         failures++;
         $display("FAIL rst_reach40 got=missing exp=step40");
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (outs() !== '0) begin
         failures++;
         $display("FAIL rst_mid_outs got=%h exp=0", outs());
      end
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      repeat (70) begin
         @(negedge clk);
         if (bus.done || bus.add_en || bus.busy) dn++;
      end
      checks++;
      if (dn !== 0) begin
         failures++;
         $display("FAIL rst_nodone got=%0d exp=0", dn);
      end
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (!(bus.step_valid && bus.step_idx == 6'd0 && bus.load_state)) begin
         failures++;
         $display("FAIL rst_restart got=%b/%0d/%b exp=1/0/1",
                  bus.step_valid, bus.step_idx, bus.load_state);
      end
      for (int k = 2; k <= 70 && ok == 0; k++) begin
         @(negedge clk);
         if (bus.done) ok = k;
      end
      checks++;
      if (ok !== 65) begin
         failures++;
         $display("FAIL rst_restart_done got=%0d exp=65", ok);
      end
      @(negedge clk);
   endtask

`ifdef MD5_STEP_STALL_EN
   task automatic test_stall();
      int n0 = 0;
      int n63 = 0;
      int done_at = -1;
      int busy_n = 0;
      int frozen_bad = 0;
      int load_bad = 0;
      logic [21:0] snap = '0;
      @(negedge clk);
      bus.start = 1'b1;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         if (k == 1) bus.start = 1'b0;
         if (bus.busy) busy_n++;
         if (bus.done && done_at < 0) done_at = k;
         bus.step_ready = 1'b1;
         if (bus.step_valid && bus.step_idx == 6'd0) begin
            n0++;
            if (!bus.load_state) load_bad++;
            if (n0 > 1 && outs() !== snap) frozen_bad++;
            snap = outs();
            if (n0 <= 3) bus.step_ready = 1'b0;
         end
         if (bus.step_valid && bus.step_idx == 6'd63) begin
            n63++;
            if (n63 > 1 && outs() !== snap) frozen_bad++;
            snap = outs();
            if (n63 <= 5) bus.step_ready = 1'b0;
         end
      end
      bus.step_ready = 1'b1;
      checks++;
      if (n0 !== 4 || n63 !== 6) begin
         failures++;
         $display("FAIL stall_hold got=%0d/%0d exp=4/6", n0, n63);
      end
      checks++;
      if (load_bad !== 0 || frozen_bad !== 0) begin
         failures++;
         $display("FAIL stall_frozen got=%0d/%0d exp=0/0", load_bad, frozen_bad);
      end
      checks++;
      if (done_at !== 73 || busy_n !== 73) begin
         failures++;
         $display("FAIL stall_done got=%0d/%0d exp=73/73", done_at, busy_n);
      end
   endtask
`endif

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
`ifdef MD5_STEP_STALL_EN
      bus.step_ready = 1'b1;
`endif
      test_reset();
      test_single();
      test_decode();
      test_back_to_back();
      test_abort();
`ifdef MD5_STEP_STALL_EN
      test_stall();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
